sign_magnitude_serial_converter: RTL and testbench
==================================================

# sign_magnitude_serial_converter

Parametrised, handshaked, bidirectional converter between sign-magnitude and two's-complement formats. The N-bit word is processed K bits per cycle, LSB chunk first. A single K-bit add/XOR slice and a carry register are reused across N/K cycles, so datapath area is traded for latency. It sits between the sign-magnitude arithmetic units and the two's-complement adders/accumulators. It replaces single-cycle combinational conversion where the area or timing budget is tight, and adds overflow reporting and reverse (TC->SM) conversion.

## Interface
- N, 10, data width in bits (N >= 2)
- K, 2, bits processed per cycle; N must be a multiple of K; K = N gives a 1-cycle conversion
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  input word offered
- in_ready  output  1  converter idle, can accept a word
- in_data  input  N  SM mode: unsigned magnitude; TC mode: two's-complement value
- in_sign  input  1  sign bit for SM->TC (1 = negative); ignored in TC->SM
- mode  input  1  0 = SM->TC, 1 = TC->SM
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_data  output  N  SM->TC: two's-complement result; TC->SM: magnitude
- out_sign  output  1  sign of the result
- out_ovf  output  1  SM->TC result not representable in N-bit two's complement

## Operation
- FSM states: IDLE, BUSY, DONE. rst low forces IDLE from any state and drops any in-flight word.
- IDLE: in_ready = 1. When in_valid = 1 on an edge:
  - capture in_data, in_sign and mode into working registers;
  - set neg = in_sign for SM->TC, or neg = in_data[N-1] for TC->SM;
  - initialise carry = neg and chunk index = 0;
  - go to BUSY.
- BUSY: in_ready = 0. Each cycle, for chunk c, compute {carry', r} = (w[cK+K-1:cK] XOR {K{neg}}) + carry.
  - Write r into the result register at chunk c; store carry'.
  - After chunk N/K-1, go to DONE.
  - The final carry is discarded (mod 2^N).
- DONE: out_valid = 1. When out_ready = 1 on an edge, go to IDLE. in_valid is ignored in BUSY and DONE.
- SM->TC:
  - out_data = in_sign ? (2^N - mag) mod 2^N : mag.
  - out_sign = out_data[N-1].
  - Negative zero (sign 1, mag 0) gives out_data = 0, out_sign = 0, out_ovf = 0.
- SM->TC overflow:
  - out_ovf = 1 iff (sign 0 and mag >= 2^(N-1)) or (sign 1 and mag > 2^(N-1)).
  - out_data still carries the wrapped value.
  - ovf is evaluated from the captured inputs at accept time.
- TC->SM:
  - out_sign = in_data[N-1].
  - out_data = |value| as unsigned N bits.
  - The most negative value -2^(N-1) maps to magnitude 2^(N-1) with out_ovf = 0. out_ovf is always 0 in this mode.
- mode, in_sign and in_data changes after the accept edge do not affect the conversion in flight.

## Timing
- Reset values (during and immediately after rst low): state IDLE, in_ready 1, out_valid 0, out_data 0, out_sign 0, out_ovf 0, carry 0, index 0.
- in_ready and out_valid are decoded from state only, with no combinational path from in_valid or out_ready.
- Accept at edge t gives out_valid = 1 from edge t+N/K. The result is held, stable, until the edge where out_valid & out_ready.
- in_ready returns to 1 the cycle after the output handshake, so minimum throughput is one word per N/K+2 cycles.
- out_ready high before out_valid has no effect. A DONE result is never overwritten.
- out_data, out_sign and out_ovf change only on the transition into DONE and on reset.
- Reset asserted mid-BUSY or mid-DONE clears all outputs asynchronously. No partial result is ever presented.

## Test plan
- N=10, K=2, SM->TC, mag 5, sign 1 -> out_data 10'h3FB, out_sign 1, out_ovf 0. out_valid rises exactly 5 cycles after the accept edge.
- N=10, K=2, SM->TC boundaries:
  - mag 0 sign 1 -> 0 / sign 0 / ovf 0;
  - mag 512 sign 1 -> 10'h200 / ovf 0;
  - mag 513 sign 1 -> 10'h1FF / ovf 1;
  - mag 512 sign 0 -> 10'h200 / ovf 1.
- N=10, K=2, TC->SM:
  - 10'h3FB -> 5 / sign 1;
  - 10'h200 -> 512 / sign 1 / ovf 0;
  - 10'h005 -> 5 / sign 0.
- Backpressure: hold out_ready = 0 for 3 cycles in DONE while driving in_valid with a new word. Required: out_data stable, in_ready 0, new word not accepted. After the out_ready pulse, in_ready = 1 next cycle and the new word converts correctly.
- Reset: assert rst low at the 2nd BUSY cycle. Required: out_valid 0 and in_ready 1 immediately. The next conversion (mag 7, sign 1 -> 10'h3F9) is correct with no residue from the dropped word.
- Parameter sweep: K in {1, 2, 5, 10} with N=10, and N=16 with K=4. Run 1000 random words in both modes with random out_ready stalls. Compare against a behavioural model on data, sign and ovf, and check latency = N/K.

Source files
------------

// File: rtl/sign_magnitude_serial_converter.sv
// Serial sign-magnitude <-> two's-complement converter: one K-bit XOR/add slice
// plus a carry register is reused for N/K cycles per word, LSB chunk first.
module sign_magnitude_serial_converter #(
    parameter int unsigned N = 10,
    parameter int unsigned K = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [N-1:0] in_data_i,
    input  logic         in_sign_i,
    input  logic         mode_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [N-1:0] out_data_o,
    output logic         out_sign_o,
    output logic         out_ovf_o
);

    localparam int unsigned NC = N / K;
    localparam int unsigned IW = (NC > 1) ? $clog2(NC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    w_q, w_d;
    logic [N-1:0]    res_q, res_d;
    logic            neg_q, neg_d;
    logic            mode_q, mode_d;
    logic            carry_q, carry_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            ovf_q, ovf_d;
    logic [N-1:0]    out_data_q, out_data_d;
    logic            out_sign_q, out_sign_d;
    logic            out_ovf_q, out_ovf_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic [K:0]      sum;
    logic [N-1:0]    res_shift;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            w_q         <= '0;
            res_q       <= '0;
            neg_q       <= 1'b0;
            mode_q      <= 1'b0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            ovf_q       <= 1'b0;
            out_data_q  <= '0;
            out_sign_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            res_q       <= res_d;
            neg_q       <= neg_d;
            mode_q      <= mode_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            ovf_q       <= ovf_d;
            out_data_q  <= out_data_d;
            out_sign_q  <= out_sign_d;
            out_ovf_q   <= out_ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        res_d       = res_q;
        neg_d       = neg_q;
        mode_d      = mode_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        ovf_d       = ovf_q;
        out_data_d  = out_data_q;
        out_sign_d  = out_sign_q;
        out_ovf_d   = out_ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        // Shared slice: conditional one's complement of the low chunk plus carry.
        sum       = (K+1)'(w_q[K-1:0] ^ {K{neg_q}}) + (K+1)'(carry_q);
        res_shift = (res_q >> K) | (N'(sum[K-1:0]) << (N - K));

        unique case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    w_d        = in_data_i;
                    mode_d     = mode_i;
                    neg_d      = mode_i ? in_data_i[N-1] : in_sign_i;
                    carry_d    = mode_i ? in_data_i[N-1] : in_sign_i;
                    idx_d      = '0;
                    // Representability is a property of the captured inputs only.
                    ovf_d      = !mode_i && (in_sign_i ? (in_data_i[N-1] && (|in_data_i[N-2:0]))
                                                       : in_data_i[N-1]);
                    in_ready_d = 1'b0;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                w_d     = w_q >> K;
                res_d   = res_shift;
                carry_d = sum[K];
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(NC - 1)) begin
                    idx_d       = '0;
                    out_data_d  = res_shift;
                    out_sign_d  = mode_q ? neg_q : res_shift[N-1];
                    out_ovf_d   = ovf_q;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sign_o  = out_sign_q;
    assign out_ovf_o   = out_ovf_q;

endmodule

// File: tb/tb_sign_magnitude_serial_converter.sv
// Directed checks on an N=10/K=2 converter plus randomised sweeps over several N/K pairs.
module tb_sign_magnitude_serial_converter;

    logic clk = 1'b0;
    logic rst_n;
    logic sw_rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Main directed instance
    logic       in_valid, in_ready, in_sign, mode, out_valid, out_ready, out_sign, out_ovf;
    logic [9:0] in_data, out_data;

    sign_magnitude_serial_converter #(.N(10), .K(2)) u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_sign_i   (in_sign),
        .mode_i      (mode),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_sign_o  (out_sign),
        .out_ovf_o   (out_ovf)
    );

    task automatic push(input logic [9:0] d, input logic s, input logic m, input string tag);
        in_valid = 1'b1;
        in_data  = d;
        in_sign  = s;
        mode     = m;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 10'h155;
        in_sign  = ~s;
        mode     = ~m;
    endtask

    task automatic wait_valid(input string tag);
        int cyc = 0;
        while (!out_valid && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 32'd5);
    endtask

    task automatic check_out(input string tag, input logic [9:0] d, input logic s, input logic o);
        check({tag, "_data"}, 32'(out_data), 32'(d));
        check({tag, "_sign"}, 32'(out_sign), 32'(s));
        check({tag, "_ovf"},  32'(out_ovf),  32'(o));
    endtask

    task automatic pop(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
        check({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    task automatic conv(input logic [9:0] d, input logic s, input logic m, input string tag,
                        input logic [9:0] ed, input logic es, input logic eo);
        push(d, s, m, tag);
        wait_valid(tag);
        check_out(tag, ed, es, eo);
        pop(tag);
    endtask

    // Randomised sweep instances
    for (genvar g = 0; g < 5; g++) begin : g_sw
        localparam int unsigned SN = (g == 4) ? 16 : 10;
        localparam int unsigned SK = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : (g == 3) ? 10 : 4;

        logic          sv, sr, ss, sm, s_rdy, s_ov, s_os, s_oo;
        logic [SN-1:0] sd, s_od;
        bit            done_l = 1'b0;

        sign_magnitude_serial_converter #(.N(SN), .K(SK)) u_sw (
            .clk_i       (clk),
            .rst_ni      (sw_rst_n),
            .in_valid_i  (sv),
            .in_ready_o  (s_rdy),
            .in_data_i   (sd),
            .in_sign_i   (ss),
            .mode_i      (sm),
            .out_valid_o (s_ov),
            .out_ready_i (sr),
            .out_data_o  (s_od),
            .out_sign_o  (s_os),
            .out_ovf_o   (s_oo)
        );

        initial begin
            logic [SN-1:0] d, ed, half;
            logic          s, m, es, eo;
            int            cyc;
            sv = 1'b0; sr = 1'b0; ss = 1'b0; sm = 1'b0; sd = '0;
            half = SN'(1) << (SN - 1);
            wait (sw_rst_n === 1'b1);
            @(negedge clk);
            for (int i = 0; i < 1000; i++) begin
                d = SN'($urandom);
                if (i % 40 == 0) d = half;
                if (i % 40 == 1) d = half + SN'(1);
                if (i % 40 == 2) d = '0;
                s = 1'($urandom_range(0, 1));
                m = 1'($urandom_range(0, 1));
                if (!m) begin
                    ed = s ? (SN'(0) - d) : d;
                    eo = s ? (d > half) : (d >= half);
                    es = ed[SN-1];
                end else begin
                    es = d[SN-1];
                    ed = es ? (SN'(0) - d) : d;
                    eo = 1'b0;
                end
                sv = 1'b1; sd = d; ss = s; sm = m;
                check($sformatf("sw%0d_rdy", g), 32'(s_rdy), 32'd1);
                @(negedge clk);
                sv = 1'b0; sd = ~d; ss = ~s; sm = ~m;
                cyc = 0;
                while (!s_ov && cyc < 64) begin
                    @(negedge clk);
                    cyc++;
                end
                check($sformatf("sw%0d_lat", g), 32'(cyc), 32'(SN / SK));
                repeat ($urandom_range(0, 3)) @(negedge clk);
                check($sformatf("sw%0d_data d=%0h s=%0d m=%0d", g, d, s, m), 32'(s_od), 32'(ed));
                check($sformatf("sw%0d_sign d=%0h s=%0d m=%0d", g, d, s, m), 32'(s_os), 32'(es));
                check($sformatf("sw%0d_ovf d=%0h s=%0d m=%0d", g, d, s, m), 32'(s_oo), 32'(eo));
                sr = 1'b1;
                @(negedge clk);
                sr = 1'b0;
            end
            done_l = 1'b1;
        end
    end

    initial begin
        int t;
        rst_n = 1'b0; sw_rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; in_sign = 1'b0; mode = 1'b0; out_ready = 1'b0;
        #22;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check_out("rst", 10'h000, 1'b0, 1'b0);
        rst_n = 1'b1; sw_rst_n = 1'b1;
        @(negedge clk);

        // out_ready high while idle must not matter
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("early_ready_valid", 32'(out_valid), 32'd0);

        conv(10'd5,   1'b1, 1'b0, "sm_m5",    10'h3FB, 1'b1, 1'b0);
        conv(10'd0,   1'b1, 1'b0, "sm_negz",  10'h000, 1'b0, 1'b0);
        conv(10'd512, 1'b1, 1'b0, "sm_m512",  10'h200, 1'b1, 1'b0);
        conv(10'd513, 1'b1, 1'b0, "sm_m513",  10'h1FF, 1'b0, 1'b1);
        conv(10'd512, 1'b0, 1'b0, "sm_p512",  10'h200, 1'b1, 1'b1);
        conv(10'd511, 1'b0, 1'b0, "sm_p511",  10'h1FF, 1'b0, 1'b0);
        conv(10'h3FB, 1'b0, 1'b1, "tc_m5",    10'd5,   1'b1, 1'b0);
        conv(10'h200, 1'b1, 1'b1, "tc_min",   10'd512, 1'b1, 1'b0);
        conv(10'h005, 1'b1, 1'b1, "tc_p5",    10'd5,   1'b0, 1'b0);

        // Backpressure with a competing word on the input
        push(10'd5, 1'b0, 1'b0, "bp");
        wait_valid("bp");
        in_valid = 1'b1; in_data = 10'd9; in_sign = 1'b1; mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_data",  32'(out_data),  32'h005);
            check("bp_hold_ready", 32'(in_ready),  32'd0);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_ready_next", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid("bp2");
        check_out("bp2", 10'h3F7, 1'b1, 1'b0);
        pop("bp2");

        // Reset during the second BUSY cycle
        push(10'd100, 1'b1, 1'b0, "rb");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rb_out_valid", 32'(out_valid), 32'd0);
        check("rb_in_ready",  32'(in_ready),  32'd1);
        check_out("rb", 10'h000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("rb_no_partial", 32'(out_valid), 32'd0);
        conv(10'd7, 1'b1, 1'b0, "post_rst", 10'h3F9, 1'b1, 1'b0);

        // Reset while holding a result in DONE
        push(10'd3, 1'b0, 1'b0, "rd");
        wait_valid("rd");
        rst_n = 1'b0;
        #1;
        check("rd_out_valid", 32'(out_valid), 32'd0);
        check("rd_out_data",  32'(out_data),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        t = 0;
        while (!(g_sw[0].done_l && g_sw[1].done_l && g_sw[2].done_l &&
                 g_sw[3].done_l && g_sw[4].done_l) && t < 90000) begin
            @(negedge clk);
            t++;
        end
        check("sweep_finished", 32'(t < 90000), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
